// File: rtl/fifo_wr_arbiter.sv
// Two-requester write arbiter in front of a FIFO, with bounded bursts so neither side can starve the other.
// Optional per-requester write counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clk_19_3,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  acc0,
    output logic                  acc1,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
`ifdef FIFO_ARB_STATS_EN
    output logic [15:0]           wr_cnt0,
    output logic [15:0]           wr_cnt1,
`endif
    output logic [1:0]            owner
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_G0   = 2'b01;
    localparam logic [1:0] S_G1   = 2'b10;
    localparam logic [3:0] LP_BMAX = 4'(BURST_MAX);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       r_last;
    logic       w_next_last;
    logic [3:0] r_cnt;
    logic [3:0] w_next_cnt;
    logic [3:0] w_cnt_inc;
    logic       w_acc0;
    logic       w_acc1;

    // State, last-owner and burst counter registers
    always_ff @(posedge clk_19_3 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_last  <= w_next_last;
            r_cnt   <= w_next_cnt;
        end
    end

    // While the FIFO is full a granted owner is frozen: no state change and
    // no burst credit consumed, so the blocked requester keeps its window.
    always_comb begin
        w_next_state = r_state;
        w_next_last  = r_last;
        w_next_cnt   = r_cnt;
        w_cnt_inc    = r_cnt + 4'd1;
        case (r_state)
            S_IDLE: begin
                w_next_cnt = 4'd0;
                if (req0 && (!req1 || r_last)) begin
                    w_next_state = S_G0;
                    w_next_last  = 1'b0;
                end else if (req1) begin
                    w_next_state = S_G1;
                    w_next_last  = 1'b1;
                end
            end
            S_G0: begin
                if (!fifo_full) begin
                    if (!req0) begin
                        w_next_cnt = 4'd0;
                        if (req1) begin
                            w_next_state = S_G1;
                            w_next_last  = 1'b1;
                        end else begin
                            w_next_state = S_IDLE;
                        end
                    end else if (w_acc0) begin
                        if (w_cnt_inc == LP_BMAX) begin
                            w_next_cnt = 4'd0;
                            if (req1) begin
                                w_next_state = S_G1;
                                w_next_last  = 1'b1;
                            end
                        end else begin
                            w_next_cnt = w_cnt_inc;
                        end
                    end
                end
            end
            S_G1: begin
                if (!fifo_full) begin
                    if (!req1) begin
                        w_next_cnt = 4'd0;
                        if (req0) begin
                            w_next_state = S_G0;
                            w_next_last  = 1'b0;
                        end else begin
                            w_next_state = S_IDLE;
                        end
                    end else if (w_acc1) begin
                        if (w_cnt_inc == LP_BMAX) begin
                            w_next_cnt = 4'd0;
                            if (req0) begin
                                w_next_state = S_G0;
                                w_next_last  = 1'b0;
                            end
                        end else begin
                            w_next_cnt = w_cnt_inc;
                        end
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    // Outputs depend only on the registered owner plus live request/full
    always_comb begin
        w_acc0       = (r_state == S_G0) && req0 && !fifo_full;
        w_acc1       = (r_state == S_G1) && req1 && !fifo_full;
        fifo_wr_data = '0;
        case (r_state)
            S_G0:    fifo_wr_data = data0;
            S_G1:    fifo_wr_data = data1;
            default: fifo_wr_data = '0;
        endcase
    end

    assign acc0       = w_acc0;
    assign acc1       = w_acc1;
    assign fifo_wr_en = w_acc0 || w_acc1;
    assign owner      = r_state;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] r_wr_cnt0;
    logic [15:0] r_wr_cnt1;

    always_ff @(posedge clk_19_3 or posedge reset) begin
        if (reset) begin
            r_wr_cnt0 <= 16'd0;
            r_wr_cnt1 <= 16'd0;
        end else begin
            if (w_acc0 && (r_wr_cnt0 != 16'hFFFF)) r_wr_cnt0 <= r_wr_cnt0 + 16'd1;
            if (w_acc1 && (r_wr_cnt1 != 16'hFFFF)) r_wr_cnt1 <= r_wr_cnt1 + 16'd1;
        end
    end

    assign wr_cnt0 = r_wr_cnt0;
    assign wr_cnt1 = r_wr_cnt1;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: expected writes are queued as stimulus is set up and
// popped by a negedge monitor; requesters advance their data on every accepted word.
module tb_fifo_wr_arbiter;

    logic       clk;
    logic       reset;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       acc0, acc1;
    logic       fifo_full;
    logic       fifo_wr_en;
    logic [7:0] fifo_wr_data;
    logic [1:0] owner;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0] wr_cnt0, wr_cnt1;
`endif

    typedef struct {
        logic       src;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   n0 = 0;
    int   n1 = 0;
    logic s0, s1;

    fifo_wr_arbiter #(.DATA_WIDTH(8), .BURST_MAX(4)) dut (
        .clk_19_3     (clk),
        .reset        (reset),
        .req0         (req0),
        .req1         (req1),
        .data0        (data0),
        .data1        (data1),
        .acc0         (acc0),
        .acc1         (acc1),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
`ifdef FIFO_ARB_STATS_EN
        .wr_cnt0      (wr_cnt0),
        .wr_cnt1      (wr_cnt1),
`endif
        .owner        (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic src, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.src  = src;
            e.data = base + 8'(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while (i < budget && !(exp_q.size() == 0 && owner == 2'b00 && !req0 && !req1)) begin
            @(negedge clk);
            i++;
        end
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk("idle_owner", 32'(owner), 32'd0);
    endtask

    // Scoreboard monitor
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (fifo_wr_en) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_write", 32'(fifo_wr_en), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_data", 32'(fifo_wr_data), 32'(e.data));
                chk("wr_src", 32'({acc1, acc0}), e.src ? 32'd2 : 32'd1);
            end
        end else begin
            chk("acc_without_wr", 32'({acc1, acc0}), 32'd0);
        end
    end

    // Requester models: next word after each accepted one, drop request when done
    initial forever begin
        @(negedge clk);
        s0 = acc0;
        s1 = acc1;
        @(posedge clk);
        #1;
        if (s0) begin
            data0 = data0 + 8'd1;
            n0--;
            if (n0 <= 0) req0 = 1'b0;
        end
        if (s1) begin
            data1 = data1 + 8'd1;
            n1--;
            if (n1 <= 0) req1 = 1'b0;
        end
    end

    initial begin
        // Reset state with both requesting, then alternate bursts from reset
        reset = 1'b1; fifo_full = 1'b0;
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h20; data1 = 8'h40; n0 = 8; n1 = 8;
        repeat (2) @(negedge clk);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
        chk("rst_acc", 32'({acc1, acc0}), 32'd0);
        push_exp(1'b0, 8'h20, 4);
        push_exp(1'b1, 8'h40, 4);
        push_exp(1'b0, 8'h24, 4);
        push_exp(1'b1, 8'h44, 4);
        @(posedge clk); #2 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("a_first_owner", 32'(owner), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("a_no_gap", 32'(fifo_wr_en), 32'd1);
            @(negedge clk);
        end
        wait_idle(50);

        // req0 alone: grant after one edge, uninterrupted past BURST_MAX
        step();
        req0 = 1'b1; n0 = 6; data0 = 8'h10;
        push_exp(1'b0, 8'h10, 6);
        @(posedge clk);
        @(negedge clk);
        chk("b_owner_after_edge", 32'(owner), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("b_wr_en", 32'(fifo_wr_en), 32'd1);
            chk("b_owner", 32'(owner), 32'd1);
            @(negedge clk);
        end
        wait_idle(20);

        // FIFO full mid GRANT1 burst: frozen, then two more writes before switching
        step();
        req1 = 1'b1; n1 = 4; data1 = 8'h60;
        push_exp(1'b1, 8'h60, 4);
        push_exp(1'b0, 8'h70, 2);
        step();
        @(negedge clk);
        chk("c_owner_g1", 32'(owner), 32'd2);
        chk("c_first_wr", 32'(fifo_wr_en), 32'd1);
        step();
        req0 = 1'b1; n0 = 2; data0 = 8'h70;
        step();
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("c_full_no_wr", 32'(fifo_wr_en), 32'd0);
            chk("c_full_owner", 32'(owner), 32'd2);
            step();
        end
        fifo_full = 1'b0;
        @(negedge clk);
        chk("c_resume_owner", 32'(owner), 32'd2);
        chk("c_resume_wr", 32'(fifo_wr_en), 32'd1);
        step();
        @(negedge clk);
        chk("c_second_owner", 32'(owner), 32'd2);
        step();
        @(negedge clk);
        chk("c_switch_owner", 32'(owner), 32'd1);
        chk("c_switch_no_gap", 32'(fifo_wr_en), 32'd1);
        wait_idle(20);

        // Asynchronous reset pulse mid-burst, then tie goes to requester 0
        step();
        req0 = 1'b1; n0 = 10; data0 = 8'h80;
        push_exp(1'b0, 8'h80, 2);
        step();
        step();
        step();
        #1 reset = 1'b1;
        #1;
        chk("d_rst_owner", 32'(owner), 32'd0);
        chk("d_rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("d_rst_acc0", 32'(acc0), 32'd0);
        #2 reset = 1'b0;
        n0 = 4; req1 = 1'b1; n1 = 1; data1 = 8'h90;
        push_exp(1'b0, 8'h82, 4);
        push_exp(1'b1, 8'h90, 1);
        @(posedge clk);
        @(negedge clk);
        chk("d_tie_owner", 32'(owner), 32'd1);
        wait_idle(30);
`ifdef FIFO_ARB_STATS_EN
        chk("d_wr_cnt0", 32'(wr_cnt0), 32'd4);
        chk("d_wr_cnt1", 32'(wr_cnt1), 32'd1);
`endif

        // req1 alone for 10 words after a fresh reset
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        req1 = 1'b1; n1 = 10; data1 = 8'hA0;
        push_exp(1'b1, 8'hA0, 10);
        @(posedge clk);
        @(negedge clk);
        chk("e_owner_g1", 32'(owner), 32'd2);
        wait_idle(60);
`ifdef FIFO_ARB_STATS_EN
        chk("e_wr_cnt0", 32'(wr_cnt0), 32'd0);
        chk("e_wr_cnt1", 32'(wr_cnt1), 32'd10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
